// File: rtl/conv2d_pe_scheduler_pkg.sv
// rtl/conv2d_pe_scheduler_pkg.sv - shared state encoding, command codes and default widths for the conv2d scheduler
package conv2d_pkg;

  localparam int CH_W_DEF  = 8;
  localparam int ROW_W_DEF = 8;

  // Scheduler FSM state encoding (fixed codes so legacy status readback stays stable)
  typedef logic [3:0] sched_state_t;
  localparam sched_state_t ST_IDLE     = 4'd0;
  localparam sched_state_t ST_FETCH    = 4'd1;
  localparam sched_state_t ST_LOAD     = 4'd2;
  localparam sched_state_t ST_ARM_LAST = 4'd3;
  localparam sched_state_t ST_ARM_WAIT = 4'd4;
  localparam sched_state_t ST_WAIT_RDY = 4'd5;
  localparam sched_state_t ST_ISSUE    = 4'd6;
  localparam sched_state_t ST_WAIT_ROW = 4'd7;
  localparam sched_state_t ST_ADV      = 4'd8;
  localparam sched_state_t ST_FINISH   = 4'd9;

  // One-hot PE command codes; at most one bit is ever set
  typedef logic [3:0] cmd_t;
  localparam cmd_t CMD_NONE = 4'b0000;
  localparam cmd_t CMD_LOAD = 4'b0001;
  localparam cmd_t CMD_MID  = 4'b0010;
  localparam cmd_t CMD_LAST = 4'b0100;
  localparam cmd_t CMD_ARM  = 4'b1000;

endpackage

// File: rtl/conv2d_pe_scheduler_if.sv
// rtl/conv2d_pe_scheduler_if.sv - command/status bundle between the scheduler and the PE control unit
interface conv2d_pe_scheduler_if;

  logic kernel_req;
  logic kernel_ack;
  logic pe_idle;
  logic pe_ready;
  logic done_1row;
  logic load_kernel_reg;
  logic stream_mid_row;
  logic stream_last_row;
  logic last_channel;

  // Scheduler side: issues requests and commands, observes PE status
  modport master (
    output kernel_req, load_kernel_reg, stream_mid_row, stream_last_row, last_channel,
    input  kernel_ack, pe_idle, pe_ready, done_1row
  );

  // PE / weight-fetch side
  modport slave (
    input  kernel_req, load_kernel_reg, stream_mid_row, stream_last_row, last_channel,
    output kernel_ack, pe_idle, pe_ready, done_1row
  );

endinterface

// File: rtl/conv2d_pe_scheduler_loop_counter.sv
// rtl/conv2d_pe_scheduler_loop_counter.sv - nested row / input-channel / output-channel counter with last flags
module conv2d_loop_counter
  import conv2d_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [CH_W-1:0]  i_in_ch,
  input  logic [CH_W-1:0]  i_out_ch,
  input  logic [ROW_W-1:0] i_rows,
  output logic [CH_W-1:0]  o_ic,
  output logic [CH_W-1:0]  o_oc,
  output logic             o_last_row,
  output logic             o_last_ic,
  output logic             o_last_oc
);

  logic [ROW_W-1:0] r_row;
  logic [CH_W-1:0]  r_ic;
  logic [CH_W-1:0]  r_oc;
  logic             w_last_row;
  logic             w_last_ic;
  logic             w_last_oc;

  // Config fields are never zero while stepping, so count-1 is a valid last index
  assign w_last_row = (r_row == i_rows   - ROW_W'(1));
  assign w_last_ic  = (r_ic  == i_in_ch  - CH_W'(1));
  assign w_last_oc  = (r_oc  == i_out_ch - CH_W'(1));

  // Rows wrap into input channels, input channels wrap into output channels
  always_ff @(posedge clk) begin
    if (!Reset || i_clear) begin
      r_row <= '0;
      r_ic  <= '0;
      r_oc  <= '0;
    end else if (i_step) begin
      if (!w_last_row) begin
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_row <= '0;
        if (!w_last_ic) begin
          r_ic <= r_ic + CH_W'(1);
        end else if (!w_last_oc) begin
          r_ic <= '0;
          r_oc <= r_oc + CH_W'(1);
        end
      end
    end
  end

  assign o_ic       = r_ic;
  assign o_oc       = r_oc;
  assign o_last_row = w_last_row;
  assign o_last_ic  = w_last_ic;
  assign o_last_oc  = w_last_oc;

endmodule

// File: rtl/conv2d_pe_scheduler.sv
// rtl/conv2d_pe_scheduler.sv - conv2d layer sequencer for the PE unit; SCHED_PERF_CNT_EN adds the stall_cycles counter
module conv2d_pe_scheduler
  import conv2d_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [CH_W-1:0]       cfg_in_ch,
  input  logic [CH_W-1:0]       cfg_out_ch,
  input  logic [ROW_W-1:0]      cfg_rows,
  conv2d_pe_scheduler_if.master pe,
  output logic [CH_W-1:0]       b_counter_output,
  output logic [CH_W-1:0]       oc_idx,
  output logic                  busy,
  output logic                  done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  sched_state_t     r_state;
  sched_state_t     w_next;
  cmd_t             w_cmd;
  cmd_t             w_cmd_out;
  logic             w_step;
  logic             w_start_ok;
  logic             w_cfg_zero;
  logic [CH_W-1:0]  r_cfg_in_ch;
  logic [CH_W-1:0]  r_cfg_out_ch;
  logic [ROW_W-1:0] r_cfg_rows;
  logic             r_armed;
  logic             r_done;
  logic             w_last_row;
  logic             w_last_ic;
  logic             w_last_oc;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_cfg_zero = (cfg_in_ch == '0) || (cfg_out_ch == '0) || (cfg_rows == '0);

  conv2d_loop_counter #(
    .CH_W  (CH_W),
    .ROW_W (ROW_W)
  ) u_loop (
    .clk        (clk),
    .Reset      (Reset),
    .i_clear    (w_start_ok),
    .i_step     (w_step),
    .i_in_ch    (r_cfg_in_ch),
    .i_out_ch   (r_cfg_out_ch),
    .i_rows     (r_cfg_rows),
    .o_ic       (b_counter_output),
    .o_oc       (oc_idx),
    .o_last_row (w_last_row),
    .o_last_ic  (w_last_ic),
    .o_last_oc  (w_last_oc)
  );

  // Next-state and command decode; every command waits on pe_idle in the same cycle
  always_comb begin
    w_next = r_state;
    w_cmd  = CMD_NONE;
    w_step = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = w_cfg_zero ? ST_FINISH : ST_FETCH;
      end
      ST_FETCH: begin
        if (pe.kernel_ack) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (pe.pe_idle) begin
          if (w_last_ic && !r_armed) begin
            w_next = ST_ARM_LAST;
          end else begin
            w_cmd  = CMD_LOAD;
            w_next = ST_WAIT_RDY;
          end
        end
      end
      ST_ARM_LAST: begin
        if (pe.pe_idle) begin
          w_cmd  = CMD_ARM;
          w_next = ST_ARM_WAIT;
        end
      end
      ST_ARM_WAIT: w_next = ST_LOAD;
      ST_WAIT_RDY: begin
        if (pe.pe_ready) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (pe.pe_idle) begin
          w_cmd  = w_last_row ? CMD_LAST : CMD_MID;
          w_next = ST_WAIT_ROW;
        end
      end
      ST_WAIT_ROW: begin
        if (pe.done_1row) w_next = ST_ADV;
      end
      ST_ADV: begin
        w_step = 1'b1;
        if (!w_last_row)                 w_next = ST_ISSUE;
        else if (!(w_last_ic && w_last_oc)) w_next = ST_FETCH;
        else                             w_next = ST_FINISH;
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // An asserted reset suppresses commands in the very cycle it is applied
  assign w_cmd_out = Reset ? w_cmd : CMD_NONE;

  // State, latched config, last-channel arm flag and the registered done pulse
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_cfg_in_ch  <= '0;
      r_cfg_out_ch <= '0;
      r_cfg_rows   <= '0;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_FINISH);
      if (w_start_ok) begin
        r_cfg_in_ch  <= cfg_in_ch;
        r_cfg_out_ch <= cfg_out_ch;
        r_cfg_rows   <= cfg_rows;
      end
      if (w_start_ok || r_state == ST_ADV) r_armed <= 1'b0;
      else if (w_cmd == CMD_ARM)           r_armed <= 1'b1;
    end
  end

  assign pe.kernel_req      = (r_state == ST_FETCH);
  assign pe.load_kernel_reg = w_cmd_out[0];
  assign pe.stream_mid_row  = w_cmd_out[1];
  assign pe.stream_last_row = w_cmd_out[2];
  assign pe.last_channel    = w_cmd_out[3];
  assign busy               = (r_state != ST_IDLE);
  assign done               = r_done;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_stall;
  logic        w_stall;

  assign w_stall = ((r_state == ST_FETCH) && !pe.kernel_ack) ||
                   ((r_state == ST_LOAD)  && !pe.pe_idle)    ||
                   ((r_state == ST_ISSUE) && !pe.pe_idle);

  // Saturating count of cycles spent waiting on the fetcher or the PE
  always_ff @(posedge clk) begin
    if (!Reset || w_start_ok) r_stall <= '0;
    else if (w_stall && (r_stall != '1)) r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles = r_stall;
`endif

endmodule
